// File: rtl/accum_ctrl_fsm.sv
// Multicycle control FSM for the accumulator processor: sequences FETCH/DECODE
// and per-opcode execute states, driving datapath strobes as registered outputs.
module accum_ctrl_fsm (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [3:0] Opcode,
  input  logic [3:0] funct,
  input  logic       LocationSelect,
  input  logic [2:0] RegSelect,
  input  logic       Zero,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AccWrite,
  output logic       EXT,
  output logic       PopPush,
  output logic       Call,
  output logic [2:0] RegDest,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       Halted,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [2:0] SP_IDX  = 3'd6;
  localparam logic [2:0] RA_IDX  = 3'd5;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_BNE  = 4'd7;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_SP_DEC, S_STK_WR, S_STK_RD, S_SP_INC, S_BRANCH,
    S_JUMP, S_CALL, S_RET_RD, S_RET_PC, S_HALT, S_ILLEGAL
  } state_t;

  state_t state;
  state_t nxt;
  logic   pc_write_q;
  logic   br_en;
  logic   br_ne;

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_IDLE:     nxt = S_FETCH;
      S_FETCH:    nxt = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          4'd0:       nxt = S_EXEC_R;
          4'd1:       nxt = S_EXEC_I;
          4'd2, 4'd3: nxt = S_MEM_ADDR;
          4'd4:       nxt = S_SP_DEC;
          4'd5:       nxt = S_STK_RD;
          4'd6, 4'd7: nxt = S_BRANCH;
          4'd8:       nxt = S_JUMP;
          4'd9:       nxt = S_CALL;
          4'd10:      nxt = S_RET_RD;
          4'd15:      nxt = S_HALT;
          default:    nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: nxt = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = S_MEM_WB;
      S_SP_DEC:   nxt = S_STK_WR;
      S_STK_RD:   nxt = S_SP_INC;
      S_CALL:     nxt = S_JUMP;
      S_RET_RD:   nxt = S_RET_PC;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  // Outputs are registered by decoding the state being entered, so each
  // strobe is glitch-free and aligned with the state it belongs to.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= S_IDLE;
      IRWrite    <= 1'b0;
      pc_write_q <= 1'b0;
      MemWrite   <= 1'b0;
      RegWrite   <= 1'b0;
      AccWrite   <= 1'b0;
      PopPush    <= 1'b0;
      Call       <= 1'b0;
      RegDest    <= 3'd0;
      PCSource   <= 2'd0;
      ALUSrcA    <= 1'b0;
      ALUSrcB    <= 2'd0;
      ALUOp      <= 4'd0;
      Halted     <= 1'b0;
      Illegal    <= 1'b0;
      br_en      <= 1'b0;
      br_ne      <= 1'b0;
    end else begin
      state      <= nxt;
      IRWrite    <= (nxt == S_FETCH);
      pc_write_q <= nxt inside {S_FETCH, S_JUMP, S_RET_PC};
      MemWrite   <= nxt inside {S_MEM_WR, S_STK_WR};
      RegWrite   <= nxt inside {S_MEM_WB, S_SP_DEC, S_STK_RD, S_SP_INC, S_CALL};
      AccWrite   <= nxt inside {S_EXEC_R, S_EXEC_I};
      PopPush    <= nxt inside {S_MEM_WB, S_STK_WR, S_STK_RD, S_RET_RD};
      Call       <= (nxt == S_CALL);
      ALUSrcA    <= nxt inside {S_EXEC_R, S_MEM_ADDR};
      Halted     <= (nxt == S_HALT);
      Illegal    <= (nxt == S_ILLEGAL);
      br_en      <= (nxt == S_BRANCH);
      br_ne      <= (Opcode == OP_BNE);
      RegDest    <= 3'd0;
      PCSource   <= 2'd0;
      ALUSrcB    <= 2'd0;
      ALUOp      <= 4'd0;
      case (nxt)
        S_FETCH: begin
          ALUSrcB <= 2'd1;
          ALUOp   <= ALU_ADD;
        end
        S_EXEC_R: begin
          ALUSrcB <= LocationSelect ? 2'd2 : 2'd0;
          ALUOp   <= funct;
        end
        S_EXEC_I: begin
          ALUSrcB <= 2'd2;
          ALUOp   <= ALU_ADD;
        end
        S_MEM_ADDR: ALUSrcB <= 2'd2;
        S_MEM_WB, S_STK_RD: RegDest <= RegSelect;
        S_SP_DEC: begin
          RegDest <= SP_IDX;
          ALUSrcB <= 2'd1;
          ALUOp   <= ALU_SUB;
        end
        S_SP_INC: begin
          RegDest <= SP_IDX;
          ALUSrcB <= 2'd1;
          ALUOp   <= ALU_ADD;
        end
        S_CALL:   RegDest  <= RA_IDX;
        S_BRANCH: PCSource <= 2'd1;
        S_JUMP:   PCSource <= 2'd2;
        S_RET_PC: PCSource <= 2'd3;
        default: ;
      endcase
    end
  end

  // Zero is only valid in the branch cycle, and the opcode only after the IR
  // loads, so these two outputs are gated combinationally.
  assign PCWrite = pc_write_q | (br_en & (Zero ^ br_ne));
  assign EXT     = (state == S_DECODE) & (Opcode inside {4'd1, 4'd2, 4'd3, 4'd6, 4'd7});

  // 20 states share a 4-bit debug field: sibling states of different
  // instructions share a code and are told apart by Opcode.
  always_comb begin
    State = 4'd0;
    case (state)
      S_IDLE:               State = 4'd0;
      S_FETCH:              State = 4'd1;
      S_DECODE:             State = 4'd2;
      S_EXEC_R:             State = 4'd3;
      S_EXEC_I:             State = 4'd4;
      S_MEM_ADDR:           State = 4'd5;
      S_MEM_RD, S_RET_RD:   State = 4'd6;
      S_MEM_WB, S_STK_RD:   State = 4'd7;
      S_MEM_WR, S_STK_WR:   State = 4'd8;
      S_SP_DEC, S_SP_INC:   State = 4'd9;
      S_BRANCH:             State = 4'd10;
      S_JUMP:               State = 4'd11;
      S_CALL:               State = 4'd12;
      S_RET_PC:             State = 4'd13;
      S_HALT:               State = 4'd14;
      S_ILLEGAL:            State = 4'd15;
      default:              State = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_accum_ctrl_fsm.sv
// Bench for accum_ctrl_fsm: per-instruction cycle sequences are pushed into an
// expected queue at issue time and a negedge monitor pops and compares.
module tb_accum_ctrl_fsm;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] C_IDLE = 4'd0, C_FETCH = 4'd1, C_DECODE = 4'd2,
                         C_EXEC_R = 4'd3, C_EXEC_I = 4'd4, C_MEM_ADDR = 4'd5,
                         C_RD = 4'd6, C_WB = 4'd7, C_WR = 4'd8, C_SP = 4'd9,
                         C_BRANCH = 4'd10, C_JUMP = 4'd11, C_CALL = 4'd12,
                         C_RET_PC = 4'd13, C_HALT = 4'd14, C_ILLEGAL = 4'd15;
  localparam int W = 26;

  typedef struct packed {
    logic [3:0] st;
    logic       ir, pcw, mw, rw, aw, ext, pp, cl;
    logic [2:0] rd;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] aop;
    logic       hlt, ill;
  } out_t;

  logic       clk, rst_n;
  logic [3:0] opcode, funct;
  logic       loc_sel, zero;
  logic [2:0] reg_sel;
  logic       ir_write, pc_write, mem_write, reg_write, acc_write, ext, pop_push, call;
  logic [2:0] reg_dest;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a, halted, illegal;
  logic [3:0] alu_op, state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  accum_ctrl_fsm dut (
    .CLK(clk), .RST_n(rst_n), .Opcode(opcode), .funct(funct),
    .LocationSelect(loc_sel), .RegSelect(reg_sel), .Zero(zero),
    .IRWrite(ir_write), .PCWrite(pc_write), .MemWrite(mem_write),
    .RegWrite(reg_write), .AccWrite(acc_write), .EXT(ext), .PopPush(pop_push),
    .Call(call), .RegDest(reg_dest), .PCSource(pc_source), .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b), .ALUOp(alu_op), .Halted(halted), .Illegal(illegal),
    .State(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic out_t actual();
    out_t o;
    o = '{st: state, ir: ir_write, pcw: pc_write, mw: mem_write, rw: reg_write,
          aw: acc_write, ext: ext, pp: pop_push, cl: call, rd: reg_dest,
          pcs: pc_source, asa: alu_src_a, asb: alu_src_b, aop: alu_op,
          hlt: halted, ill: illegal};
    return o;
  endfunction

  function automatic out_t blank(input logic [3:0] st);
    out_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic check_vec(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d vec=%h expected state=%0d vec=%h",
               name, got.st, got, exp.st, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // reference model: the per-cycle output sequence of one instruction
  task automatic issue(input logic [3:0] op, input logic [3:0] fn, input logic ls,
                       input logic [2:0] rs, input logic z);
    out_t o;
    opcode = op; funct = fn; loc_sel = ls; reg_sel = rs; zero = z;
    o = blank(C_FETCH); o.ir = 1; o.pcw = 1; o.asb = 2'd1; o.aop = ALU_ADD;
    exp_q.push_back(o);
    o = blank(C_DECODE); o.ext = op inside {4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
    exp_q.push_back(o);
    case (op)
      4'd0: begin
        o = blank(C_EXEC_R); o.aw = 1; o.asa = 1; o.asb = ls ? 2'd2 : 2'd0; o.aop = fn;
        exp_q.push_back(o);
      end
      4'd1: begin
        o = blank(C_EXEC_I); o.aw = 1; o.asb = 2'd2; o.aop = ALU_ADD;
        exp_q.push_back(o);
      end
      4'd2, 4'd3: begin
        o = blank(C_MEM_ADDR); o.asa = 1; o.asb = 2'd2; exp_q.push_back(o);
        if (op == 4'd2) begin
          exp_q.push_back(blank(C_RD));
          o = blank(C_WB); o.pp = 1; o.rw = 1; o.rd = rs; exp_q.push_back(o);
        end else begin
          o = blank(C_WR); o.mw = 1; exp_q.push_back(o);
        end
      end
      4'd4: begin
        o = blank(C_SP); o.rw = 1; o.rd = 3'd6; o.aop = ALU_SUB; o.asb = 2'd1; exp_q.push_back(o);
        o = blank(C_WR); o.mw = 1; o.pp = 1; exp_q.push_back(o);
      end
      4'd5: begin
        o = blank(C_WB); o.pp = 1; o.rw = 1; o.rd = rs; exp_q.push_back(o);
        o = blank(C_SP); o.rw = 1; o.rd = 3'd6; o.aop = ALU_ADD; o.asb = 2'd1; exp_q.push_back(o);
      end
      4'd6, 4'd7: begin
        o = blank(C_BRANCH); o.pcs = 2'd1; o.pcw = (op == 4'd6) ? z : !z;
        exp_q.push_back(o);
      end
      4'd8, 4'd9: begin
        if (op == 4'd9) begin
          o = blank(C_CALL); o.cl = 1; o.rw = 1; o.rd = 3'd5; exp_q.push_back(o);
        end
        o = blank(C_JUMP); o.pcw = 1; o.pcs = 2'd2; exp_q.push_back(o);
      end
      4'd10: begin
        o = blank(C_RD); o.pp = 1; exp_q.push_back(o);
        o = blank(C_RET_PC); o.pcw = 1; o.pcs = 2'd3; exp_q.push_back(o);
      end
      4'd15: begin
        o = blank(C_HALT); o.hlt = 1;
        repeat (12) exp_q.push_back(o);
      end
      default: begin
        o = blank(C_ILLEGAL); o.ill = 1; exp_q.push_back(o);
      end
    endcase
  endtask

  // driver tasks
  task automatic wait_fetch();
    bit seen;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (ir_write) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fetch_timeout: got IRWrite=0 for 8 cycles expected IRWrite=1");
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input logic ls,
                           input logic [2:0] rs, input logic z);
    wait_fetch();
    issue(op, fn, ls, rs, z);
    if (op == 4'd15) begin
      repeat (14) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("halt_reset", actual(), blank(C_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic push_then_reset();
    wait_fetch();
    issue(4'd4, 4'd0, 1'b0, 3'd0, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    check_bit("stk_wr_memwrite_before_reset", mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("stk_wr_memwrite_dropped", mem_write, 1'b0);
    check_vec("mid_reset_state", actual(), blank(C_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        out_t e;
        e = out_t'(exp_q.pop_front());
        check_vec("cycle", actual(), e);
        check_bit("mem_reg_exclusive", mem_write & reg_write, 1'b0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = 4'd0; funct = 4'd0; loc_sel = 1'b0; reg_sel = 3'd0; zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_vec("reset_outputs", actual(), blank(C_IDLE));
    end
    rst_n = 1'b1;

    run_instr(4'd0, 4'h2, 1'b0, 3'd0, 1'b0);   // R-type
    run_instr(4'd0, 4'h7, 1'b1, 3'd3, 1'b1);   // R-type, immediate operand
    run_instr(4'd2, 4'h0, 1'b0, 3'd1, 1'b0);   // lw
    run_instr(4'd3, 4'h0, 1'b0, 3'd4, 1'b0);   // sw
    run_instr(4'd9, 4'h0, 1'b0, 3'd0, 1'b0);   // call
    run_instr(4'd6, 4'h0, 1'b0, 3'd0, 1'b0);   // beq, not taken
    run_instr(4'd7, 4'h0, 1'b0, 3'd0, 1'b0);   // bne, taken
    run_instr(4'd6, 4'h0, 1'b0, 3'd0, 1'b1);
    run_instr(4'd7, 4'h0, 1'b0, 3'd0, 1'b1);
    run_instr(4'd8, 4'h0, 1'b0, 3'd0, 1'b0);   // j
    run_instr(4'd10, 4'h0, 1'b0, 3'd0, 1'b0);  // ret
    run_instr(4'd5, 4'h0, 1'b0, 3'd2, 1'b0);   // pop
    run_instr(4'd4, 4'h0, 1'b0, 3'd0, 1'b0);   // push
    run_instr(4'd1, 4'h0, 1'b0, 3'd0, 1'b0);   // addi
    run_instr(4'd12, 4'h0, 1'b0, 3'd0, 1'b0);  // illegal
    run_instr(4'd15, 4'h0, 1'b0, 3'd0, 1'b0);  // halt, then reset
    push_then_reset();

    for (int n = 0; n < 200; n++) begin
      run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
    end

    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_ctrl_fsm.md
# accum_ctrl_fsm

Multicycle control unit for the accumulator processor. It consumes the decoded instruction fields produced by the PhaseTwo datapath (Opcode, funct, LocationSelect) plus the ALU zero flag. Each cycle it drives the datapath strobes that the PhaseTwo bench drives by hand: IRWrite, RegWrite, RegDest, MemWrite, EXT, PopPush and Call. It also drives the PC and ALU selects. It sits between the IR decode fields and the datapath control inputs in the top-level CPU.

## Interface
- SP_IDX, 3'd6: register-file index of the stack pointer.
- RA_IDX, 3'd5: register-file index of the return-address register.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- Opcode  in  4  IR[15:12].
- funct  in  4  IR[3:0]; R-type ALU function.
- LocationSelect  in  1  IR operand-source bit; 1 selects the immediate.
- RegSelect  in  3  IR register field.
- Zero  in  1  ALU result-equals-zero flag, sampled in BRANCH.
- IRWrite, PCWrite, MemWrite, RegWrite, AccWrite, EXT, PopPush, Call  out  1 each  datapath strobes and selects.
- RegDest  out  3  register-file write index.
- PCSource  out  2  PC select: 0 = ALU, 1 = branch target, 2 = jump immediate, 3 = memory data.
- ALUSrcA  out  1  ALU A-input select: 0 = PC, 1 = accumulator/register.
- ALUSrcB  out  2  ALU B-input select: 0 = register, 1 = constant 1, 2 = immediate.
- ALUOp  out  4  ALU operation; equals funct in EXEC_R, else a fixed code per state.
- Halted  out  1  high while the FSM is in HALT.
- Illegal  out  1  one-cycle pulse on an undefined opcode.
- State  out  4  current state encoding, for debug.

## Operation
- Outputs are Moore-type, decoded from the state register only.
- Every output not listed for a state is 0.
- IDLE (entered on reset): all outputs 0; unconditional transition to FETCH.
- FETCH: IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 1, ALUOp = ADD. Transition to DECODE.
- DECODE: EXT = 1 for opcodes 1, 2, 3, 6 and 7 (sign-extend); else 0. Branch on Opcode:
  - 0 → EXEC_R: AccWrite = 1, ALUSrcA = 1, ALUSrcB = LocationSelect ? 2 : 0, ALUOp = funct. Then FETCH.
  - 1 (addi) → EXEC_I: AccWrite = 1, ALUSrcB = 2, ALUOp = ADD. Then FETCH.
  - 2 (lw) / 3 (sw) → MEM_ADDR: ALUSrcA = 1, ALUSrcB = 2. Then MEM_RD for lw, MEM_WR for sw.
    - MEM_RD: no strobes; RAM read cycle. Then MEM_WB.
    - MEM_WB: PopPush = 1, RegWrite = 1, RegDest = RegSelect. Then FETCH.
    - MEM_WR: MemWrite = 1. Then FETCH.
  - 4 (push) → SP_DEC: RegWrite = 1, RegDest = SP_IDX, ALUOp = SUB, ALUSrcB = 1. Then STK_WR.
    - STK_WR: MemWrite = 1, PopPush = 1. Then FETCH.
  - 5 (pop) → STK_RD: PopPush = 1, RegWrite = 1, RegDest = RegSelect. Then SP_INC.
    - SP_INC: RegWrite = 1, RegDest = SP_IDX, ALUOp = ADD, ALUSrcB = 1. Then FETCH.
  - 6 (beq) / 7 (bne) → BRANCH: PCSource = 1. PCWrite = Zero for beq, !Zero for bne. Then FETCH.
  - 8 (j) → JUMP: PCWrite = 1, PCSource = 2. Then FETCH.
  - 9 (call) → CALL: Call = 1, RegWrite = 1, RegDest = RA_IDX. Then JUMP.
  - 10 (ret) → RET_RD: PopPush = 1. Then RET_PC.
    - RET_PC: PCWrite = 1, PCSource = 3. Then FETCH.
  - 15 → HALT: Halted = 1. Stays in HALT until reset.
  - 11–14 → ILLEGAL: Illegal = 1. Then FETCH.
- At most one of MemWrite and RegWrite is high in any state.

## Timing
- Reset: RST_n low forces State = IDLE asynchronously, within the same cycle, not waiting for a clock edge. All outputs are 0 during and immediately after reset.
- First FETCH occurs on the first rising edge after RST_n deasserts.
- Instruction lengths in cycles, counted FETCH to next FETCH:
  - R-type, addi, branch, jump, illegal: 3.
  - sw, push, pop, ret: 4.
  - call: 4 (FETCH, DECODE, CALL, JUMP).
  - lw: 5.
- RST_n asserted mid-instruction aborts it. Any MemWrite or RegWrite strobe in progress drops immediately. No partial state is retained.
- Zero is sampled combinationally during the BRANCH state only.
- Opcode and funct are read in DECODE and the cycle after it. The IR holds them stable because IRWrite is asserted only in FETCH.

## Test plan
- Reset: hold RST_n = 0 for 2 cycles, release. Expect State = IDLE and all outputs 0 during reset. Expect IRWrite = 1 and PCWrite = 1 on the following cycle.
- R-type: Opcode = 0, funct = 4'h2, LocationSelect = 0. Expect the sequence FETCH, DECODE, EXEC_R, with ALUOp = 2, AccWrite = 1, ALUSrcB = 0. Expect the next FETCH 3 cycles after the first.
- lw: Opcode = 2, RegSelect = 3'b001. Expect EXT = 1 in DECODE. Expect MEM_WB to assert PopPush = 1, RegWrite = 1, RegDest = 1. Expect MemWrite = 0 throughout. Total 5 cycles.
- call: Opcode = 9. Expect Call = 1, RegWrite = 1, RegDest = 5 for exactly one cycle. The next cycle must show PCWrite = 1 and PCSource = 2.
- Branch: beq with Zero = 0 gives PCWrite = 0 in BRANCH. bne with Zero = 0 gives PCWrite = 1 and PCSource = 1.
- Illegal, halt, and mid-instruction reset:
  - Opcode = 12 gives Illegal high for exactly 1 cycle, then FETCH.
  - Opcode = 15 keeps Halted = 1 for 10 or more cycles with no strobes.
  - Assert RST_n low during STK_WR; MemWrite must drop before the next clock edge.
